// File: rtl/rotate_sequencer.sv
// rotate_sequencer: command-driven controller for a 4-bit rotating register.
// Accepts LOAD / ROTL / ROTR / ASR commands over valid/ready, steers the
// register's control and data pins one cycle at a time, and strobes done
// with the resulting register value. The register reloads every clock, so
// idle cycles feed its own output back in to hold the contents.
module rotate_sequencer #(
    parameter int MAX_STEPS = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_count,
    input  logic [3:0] cmd_data,
    input  logic [3:0] q_in,
    output logic       reg_reset,
    output logic       ParallelLoadn,
    output logic       RotateRight,
    output logic       ASRight,
    output logic [3:0] Data_IN,
    output logic       done,
    output logic [3:0] result,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ROTL = 2'b01;
    localparam logic [1:0] OP_ASR  = 2'b11;

    localparam logic [2:0] MAX_CNT = 3'(MAX_STEPS);

    state_t     state_q;
    logic [1:0] op_q;
    logic [3:0] data_q;
    logic [2:0] count_q;
    logic [2:0] count_clamped;

    // Step counts above the configured maximum are clamped before latching.
    always_comb begin
        count_clamped = (cmd_count > MAX_CNT) ? MAX_CNT : cmd_count;
    end

    // Controller FSM: command latch, step counter and state transitions.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            op_q    <= 2'b00;
            data_q  <= 4'b0000;
            count_q <= 3'd0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    state_q <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        data_q  <= cmd_data;
                        count_q <= count_clamped;
                        if (cmd_op == OP_LOAD) begin
                            state_q <= ST_LOAD;
                        end else if (count_clamped != 3'd0) begin
                            state_q <= ST_SHIFT;
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_DONE;
                end
                ST_SHIFT: begin
                    // The step taken in the cycle the counter reads 1 is the last.
                    if (count_q == 3'd1) begin
                        state_q <= ST_DONE;
                    end
                    count_q <= count_q - 3'd1;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Pin decode from the current state and latched command.
    always_comb begin
        cmd_ready     = 1'b0;
        reg_reset     = 1'b0;
        ParallelLoadn = 1'b0;
        RotateRight   = 1'b0;
        ASRight       = 1'b0;
        Data_IN       = q_in;
        done          = 1'b0;
        result        = 4'b0000;
        busy          = 1'b1;
        case (state_q)
            ST_CLEAR: begin
                reg_reset     = 1'b1;
                ParallelLoadn = 1'b1;
                Data_IN       = 4'b0000;
            end
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_LOAD: begin
                Data_IN = data_q;
            end
            ST_SHIFT: begin
                ParallelLoadn = 1'b1;
                RotateRight   = (op_q != OP_ROTL);
                ASRight       = (op_q == OP_ASR);
                Data_IN       = 4'b0000;
            end
            ST_DONE: begin
                done   = 1'b1;
                result = q_in;
            end
            default: begin
                // Unreachable encodings fall back to holding the register.
            end
        endcase
    end

endmodule

// File: tb/tb_rotate_sequencer.sv
// Bench for rotate_sequencer: includes a behavioural model of the 4-bit
// rotating register, a directed vector table, hand-written corner sequences
// and a randomized phase against an arithmetic reference model.
module tb_rotate_sequencer;

    localparam int MAXS = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [2:0] cmd_count = 3'd0;
    logic [3:0] cmd_data = 4'd0;
    logic [3:0] q_in;
    logic       cmd_ready, reg_reset, ParallelLoadn, RotateRight, ASRight;
    logic [3:0] Data_IN, result;
    logic       done, busy;

    int n_vec = 0;
    int n_bad = 0;
    int accept_cnt = 0;

    rotate_sequencer #(.MAX_STEPS(MAXS)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_data(cmd_data),
        .q_in(q_in), .reg_reset(reg_reset), .ParallelLoadn(ParallelLoadn),
        .RotateRight(RotateRight), .ASRight(ASRight), .Data_IN(Data_IN),
        .done(done), .result(result), .busy(busy)
    );

    always #5 clock = ~clock;

    // Model of the external rotating register (no hold mode).
    logic [3:0] reg_q = 4'b1011;
    assign q_in = reg_q;
    always @(posedge clock) begin
        if (reg_reset)          reg_q <= 4'b0000;
        else if (!ParallelLoadn) reg_q <= Data_IN;
        else if (RotateRight)   reg_q <= {(ASRight ? reg_q[3] : reg_q[0]), reg_q[3:1]};
        else                    reg_q <= {reg_q[2:0], reg_q[3]};
    end

    // Handshake monitor.
    always @(posedge clock) begin
        if (cmd_valid && cmd_ready) accept_cnt <= accept_cnt + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: expected result of a shift command on value v.
    function automatic int ref_shift(input int op, input int n, input int v);
        int ne;
        int r;
        int s;
        ne = (n > MAXS) ? MAXS : n;
        r  = ne % 4;
        case (op)
            1: return ((v << r) | (v >> (4 - r))) & 15;
            2: return ((v >> r) | (v << (4 - r))) & 15;
            3: begin
                s = (v >= 8) ? v - 16 : v;
                return (s >>> ne) & 15;
            end
            default: return v & 15;
        endcase
    endfunction

    function automatic int ref_lat(input int op, input int n);
        int ne;
        ne = (n > MAXS) ? MAXS : n;
        if (op == 0) return 2;
        return (ne == 0) ? 1 : ne + 1;
    endfunction

    // Issue one command; returns result at done and cycles from accept to done.
    task automatic run_cmd(input logic [1:0] op, input logic [2:0] cnt,
                           input logic [3:0] data, output int res, output int lat);
        int budget;
        @(negedge clock);
        budget = 0;
        while (!cmd_ready && budget < 50) begin
            @(negedge clock);
            budget++;
        end
        if (budget >= 50) check("ready_timeout", 0, 1);
        cmd_op    = op;
        cmd_count = cnt;
        cmd_data  = data;
        cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        res = done ? int'(result) : -1;
        $display("cmd op=%0d cnt=%0d data=%h -> result=%0d latency=%0d", op, cnt, data, res, lat);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [2:0] cnt;
        logic [3:0] data;
        int         exp_res;
        int         exp_lat;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int res, lat, base, k, ref_v, rop, rcnt, rdat, exp_r;

        tbl[0]  = '{2'd0, 3'd0, 4'h9, 9,  2};   // LOAD 1001
        tbl[1]  = '{2'd1, 3'd1, 4'h0, 3,  2};   // ROTL 1 -> 0011
        tbl[2]  = '{2'd0, 3'd0, 4'h9, 9,  2};
        tbl[3]  = '{2'd2, 3'd1, 4'h0, 12, 2};   // ROTR 1 -> 1100
        tbl[4]  = '{2'd0, 3'd0, 4'h8, 8,  2};
        tbl[5]  = '{2'd3, 3'd2, 4'h0, 14, 3};   // ASR 2 -> 1110
        tbl[6]  = '{2'd0, 3'd0, 4'h1, 1,  2};
        tbl[7]  = '{2'd1, 3'd5, 4'h0, 2,  6};   // ROTL 5 -> 0010
        tbl[8]  = '{2'd0, 3'd0, 4'h6, 6,  2};
        tbl[9]  = '{2'd2, 3'd0, 4'h0, 6,  1};   // ROTR 0 -> unchanged
        tbl[10] = '{2'd2, 3'd7, 4'h0, 3,  6};   // ROTR 7 clamps to 5 -> 0011
        tbl[11] = '{2'd3, 3'd7, 4'h0, 0,  6};   // ASR 7 clamps to 5 -> 0000

        // Reset release with the register holding an arbitrary value.
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("clear_reg_reset", reg_reset, 1);
        check("clear_busy", busy, 1);
        check("clear_ready", cmd_ready, 0);
        check("clear_done", done, 0);
        @(negedge clock);
        check("idle_reg_reset", reg_reset, 0);
        check("idle_ready", cmd_ready, 1);
        check("idle_busy", busy, 0);
        check("reg_cleared", q_in, 0);

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            run_cmd(tbl[i].op, tbl[i].cnt, tbl[i].data, res, lat);
            check("tbl_result", res, tbl[i].exp_res);
            check("tbl_latency", lat, tbl[i].exp_lat);
            @(negedge clock);
            check("tbl_done_pulse", done, 0);
            check("tbl_ready_after", cmd_ready, 1);
            if (i == 0) begin
                repeat (10) @(negedge clock);
                check("hold_10_idle", q_in, 9);
            end
        end

        // cmd_valid held through busy cycles: accepted exactly once, at IDLE.
        @(negedge clock);
        base = accept_cnt;
        cmd_op = 2'd0; cmd_count = 3'd0; cmd_data = 4'b0101; cmd_valid = 1'b1;
        @(negedge clock);
        check("held_busy", cmd_ready, 0);
        cmd_op = 2'd1; cmd_count = 3'd1; cmd_data = 4'b0000;
        k = 0;
        while (accept_cnt < base + 2 && k < 20) begin
            @(negedge clock);
            k++;
            if (k == 1) check("held_first_done", result, 5);
        end
        cmd_valid = 1'b0;
        check("held_accept_cycle", k, 3);
        @(negedge clock);
        check("held_second_done", done, 1);
        check("held_second_result", result, 10);
        repeat (3) @(negedge clock);
        check("held_accept_once", accept_cnt - base, 2);

        // Reset during the 3rd SHIFT cycle of ROTL 6.
        run_cmd(2'd0, 3'd0, 4'b0011, res, lat);
        check("pre_reset_load", res, 3);
        @(negedge clock);
        cmd_op = 2'd1; cmd_count = 3'd6; cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("mid_shift_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("rst_reg_reset", reg_reset, 1);
        check("rst_pln", ParallelLoadn, 1);
        check("rst_rr", RotateRight, 0);
        check("rst_asr", ASRight, 0);
        check("rst_data_in", Data_IN, 0);
        check("rst_ready", cmd_ready, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_busy", busy, 1);
        @(negedge clock);
        check("rst_hold_done", done, 0);
        reset = 1'b0;
        #1;
        check("rel_clear", reg_reset, 1);
        check("rel_done", done, 0);
        @(negedge clock);
        check("rel_idle_ready", cmd_ready, 1);
        check("rel_reg_reset_off", reg_reset, 0);
        check("rel_reg_zero", q_in, 0);

        // Randomized commands against the reference model.
        ref_v = 0;
        for (int i = 0; i < 40; i++) begin
            rop  = int'($urandom_range(0, 3));
            rcnt = int'($urandom_range(0, 7));
            rdat = int'($urandom_range(0, 15));
            exp_r = (rop == 0) ? rdat : ref_shift(rop, rcnt, ref_v);
            run_cmd(2'(rop), 3'(rcnt), 4'(rdat), res, lat);
            check("rnd_result", res, exp_r);
            check("rnd_latency", lat, ref_lat(rop, rcnt));
            ref_v = exp_r;
            repeat ($urandom_range(0, 3)) @(negedge clock);
            check("rnd_hold", q_in, ref_v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
